// File: rtl/seq_alu_pkg.sv
// Shared mode encodings and saturation-limit helpers for the sequential ALU.
package seq_alu_pkg;

  localparam logic [1:0] MODE_UADD = 2'd0;
  localparam logic [1:0] MODE_SADD = 2'd1;
  localparam logic [1:0] MODE_SSUB = 2'd2;
  localparam logic [1:0] MODE_SACC = 2'd3;

  // Limits are returned as 32-bit patterns; callers keep the low n bits.
  function automatic logic [31:0] sat_max(input int unsigned n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  // Low n bits of -2^(n-1) are a lone sign bit.
  function automatic logic [31:0] sat_min(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Combinational datapath: add/sub in WIDTH+1 bits and saturating accumulate.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]     mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0] acc,
  output logic [WIDTH:0] result,
  output logic           sat
);

  localparam int N = WIDTH + 1;

  logic [N-1:0] ua, ub, sa, sb, s;
  logic [N:0]   sum;
  logic [N-1:0] lim_max, lim_min;

  assign ua      = {1'b0, in_a};
  assign ub      = {1'b0, in_b};
  assign sa      = {in_a[WIDTH-1], in_a};
  assign sb      = {in_b[WIDTH-1], in_b};
  assign s       = sa + sb;
  assign sum     = {acc[N-1], acc} + {s[N-1], s};
  assign lim_max = N'(sat_max(N));
  assign lim_min = N'(sat_min(N));

  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (mode)
      MODE_UADD: result = ua + ub;
      MODE_SADD: result = s;
      MODE_SSUB: result = sa - sb;
      default: begin
        // Overflow shows as disagreement between the two top bits of the N+1 sum.
        if (sum[N] != sum[N-1]) begin
          sat    = 1'b1;
          result = sum[N] ? lim_min : lim_max;
        end else begin
          result = sum[N-1:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and a saturating accumulator.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             sat
);

  logic             out_valid_reg;
  logic [WIDTH:0]   out_reg;
  logic             sat_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   acc_base;
  logic [WIDTH:0]   core_result;
  logic             core_sat;
  logic             accept;
  logic             acc_beat;

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign acc_beat  = accept && (mode == MODE_SACC);
  // A clear arriving with an accumulate beat restarts the sum from zero.
  assign acc_base  = acc_clr ? '0 : acc_reg;

  seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .mode   (mode),
    .in_a   (in_a),
    .in_b   (in_b),
    .acc    (acc_base),
    .result (core_result),
    .sat    (core_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      sat_reg       <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_reg       <= core_result;
      sat_reg       <= core_sat;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
    end
  end

  // acc only samples the datapath on an accepted beat, so idle X inputs never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (acc_beat) begin
      acc_reg <= core_result;
    end else if (acc_clr) begin
      acc_reg <= '0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign sat       = sat_reg;

endmodule
